// File: rtl/enc_pkg.sv
// Shared constants and types for the rotary encoder front-end and rotational_encoder.
package enc_pkg;

  localparam logic ENC_A_IDLE  = 1'b0;
  localparam logic ENC_B_IDLE  = 1'b0;
  localparam logic ENC_PB_IDLE = 1'b1;

  localparam int GLITCH_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    PB_NONE    = 2'd0,
    PB_PRESS   = 2'd1,
    PB_RELEASE = 2'd2
  } pb_press_type;

  // Debounce counter width: $clog2(n), never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One input channel: SYNC_STAGES-deep synchroniser followed by an N-cycle
// stability debouncer; flags a glitch when a mismatch run aborts early.
module debounce_chan
  import enc_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   N           = 4,
  parameter logic IDLE        = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_raw,
  output logic d_db,
  output logic glitch
);

  localparam int             CW   = cnt_width(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s_out;
  logic [CW-1:0]          cnt;

  // Chain is preloaded with the idle level so reset release creates no edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync <= {SYNC_STAGES{IDLE}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d_raw};
    end
  end

  assign s_out = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d_db <= IDLE;
      cnt  <= '0;
    end else if (s_out == d_db) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      d_db <= s_out;
      cnt  <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign glitch = (cnt != '0) && (s_out == d_db);

endmodule

// File: rtl/encoder_input_conditioner.sv
// Rotary encoder front-end: clean A/B/PB for rotational_encoder, pushbutton
// edge strobes and a saturating glitch counter for bring-up diagnostics.
module encoder_input_conditioner
  import enc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int AB_DEBOUNCE = 100,
  parameter int PB_DEBOUNCE = 50000,
  parameter int GLITCH_W    = GLITCH_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                a_raw,
  input  logic                b_raw,
  input  logic                pb_raw,
  input  logic                glitch_clr,
  output logic                A_db,
  output logic                B_db,
  output logic                PB_db,
  output logic                pb_press,
  output logic                pb_release,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  if (SYNC_STAGES < 2 || AB_DEBOUNCE < 1 || PB_DEBOUNCE < 1) begin : g_param_check
    $error("encoder_input_conditioner: SYNC_STAGES must be >= 2 and debounce lengths >= 1");
  end

  logic         a_glitch;
  logic         b_glitch;
  logic         pb_glitch;
  logic         pb_prev;
  pb_press_type pb_evt;

  debounce_chan #(
    .SYNC_STAGES(SYNC_STAGES),
    .N          (AB_DEBOUNCE),
    .IDLE       (ENC_A_IDLE)
  ) u_a (
    .clk   (clk),
    .rstn  (rstn),
    .d_raw (a_raw),
    .d_db  (A_db),
    .glitch(a_glitch)
  );

  debounce_chan #(
    .SYNC_STAGES(SYNC_STAGES),
    .N          (AB_DEBOUNCE),
    .IDLE       (ENC_B_IDLE)
  ) u_b (
    .clk   (clk),
    .rstn  (rstn),
    .d_raw (b_raw),
    .d_db  (B_db),
    .glitch(b_glitch)
  );

  debounce_chan #(
    .SYNC_STAGES(SYNC_STAGES),
    .N          (PB_DEBOUNCE),
    .IDLE       (ENC_PB_IDLE)
  ) u_pb (
    .clk   (clk),
    .rstn  (rstn),
    .d_raw (pb_raw),
    .d_db  (PB_db),
    .glitch(pb_glitch)
  );

  always_comb begin
    pb_evt = PB_NONE;
    if (pb_prev && !PB_db) begin
      pb_evt = PB_PRESS;
    end else if (!pb_prev && PB_db) begin
      pb_evt = PB_RELEASE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pb_prev    <= ENC_PB_IDLE;
      pb_press   <= 1'b0;
      pb_release <= 1'b0;
    end else begin
      pb_prev    <= PB_db;
      pb_press   <= (pb_evt == PB_PRESS);
      pb_release <= (pb_evt == PB_RELEASE);
    end
  end

  // Two guard bits so a 0..3 increment on a saturated count cannot wrap.
  logic [1:0]          glitch_sum;
  logic [GLITCH_W+1:0] glitch_next;

  assign glitch_sum  = {1'b0, a_glitch} + {1'b0, b_glitch} + {1'b0, pb_glitch};
  assign glitch_next = {2'b00, glitch_cnt} + (GLITCH_W + 2)'(glitch_sum);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      glitch_cnt <= '0;
    end else if (glitch_clr) begin
      glitch_cnt <= '0;
    end else if (glitch_next[GLITCH_W+1:GLITCH_W] != 2'b00) begin
      glitch_cnt <= '1;
    end else begin
      glitch_cnt <= glitch_next[GLITCH_W-1:0];
    end
  end

endmodule
